// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single external memory port between instruction fetch (IF) and
// memory access (MA). One transaction owns the port at a time; the winner's
// command is registered for the whole transaction, and the completion pulse
// and read data are returned to the owner one cycle after memAck.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | port free; requests sampled, combinational grant issued
// ST_IF_BUSY | IF read in flight; memReq held until memAck, flush kills it
// ST_MA_BUSY | MA read/write in flight; memReq held until memAck
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    output logic                  ifGrant,
    output logic                  ifDone,
    output logic [DATA_WIDTH-1:0] ifReadData,

    input  logic                  maReq,
    input  logic                  maWrite,
    input  logic [ADDR_WIDTH-1:0] maAddr,
    input  logic [DATA_WIDTH-1:0] maWriteData,
    output logic                  maGrant,
    output logic                  maDone,
    output logic [DATA_WIDTH-1:0] maReadData,

    output logic                  memReq,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic                  memAck,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_MA_BUSY = 2'd2
    } state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e                state_q,    state_d;
    logic [3:0]            starve_q,   starve_d;
    logic                  kill_q,     kill_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q,  cmd_addr_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic                  if_done_q,  if_done_d;
    logic                  ma_done_q,  ma_done_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] ma_rdata_q, ma_rdata_d;

    logic in_idle;
    logic if_cand;
    logic starved;
    logic ma_win;
    logic if_win;

    // Arbitration: MA has priority unless IF has waited through STARVE_LIMIT
    // MA grants. A flushed IF request is not a candidate, so MA may still use
    // the port in that cycle. Grants are held off while reset is asserted.
    always_comb begin
        in_idle = (state_q == ST_IDLE);
        if_cand = ifReq && !flush;
        starved = (starve_q == STARVE_MAX);
        ma_win  = in_idle && rst && maReq && !(if_cand && starved);
        if_win  = in_idle && rst && if_cand && !ma_win;
    end

    // Next-state, command capture, starvation counter, kill and completion.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        kill_d      = kill_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_write_d = cmd_write_q;
        cmd_wdata_d = cmd_wdata_q;
        if_done_d   = 1'b0;
        ma_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        ma_rdata_d  = ma_rdata_q;

        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (ma_win) begin
                    cmd_addr_d  = maAddr;
                    cmd_write_d = maWrite;
                    cmd_wdata_d = maWriteData;
                    state_d     = ST_MA_BUSY;
                end else if (if_win) begin
                    cmd_addr_d  = ifAddr;
                    cmd_write_d = 1'b0;
                    state_d     = ST_IF_BUSY;
                end

                // Counts how many MA grants IF has sat through.
                if (if_win || !ifReq) begin
                    starve_d = 4'd0;
                end else if (ma_win && (starve_q != STARVE_MAX)) begin
                    starve_d = starve_q + 4'd1;
                end
            end

            ST_IF_BUSY: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                // A killed fetch still completes on the bus, but its data and
                // done pulse are dropped, including a flush in the ack cycle.
                if (memAck) begin
                    state_d = ST_IDLE;
                    kill_d  = 1'b0;
                    if (!(kill_q || flush)) begin
                        if_rdata_d = memReadData;
                        if_done_d  = 1'b1;
                    end
                end
            end

            ST_MA_BUSY: begin
                if (memAck) begin
                    state_d    = ST_IDLE;
                    ma_rdata_d = memReadData;
                    ma_done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers; reset drops any in-flight command at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= 4'd0;
            kill_q      <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_write_q <= 1'b0;
            cmd_wdata_q <= '0;
            if_done_q   <= 1'b0;
            ma_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            ma_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            kill_q      <= kill_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_write_q <= cmd_write_d;
            cmd_wdata_q <= cmd_wdata_d;
            if_done_q   <= if_done_d;
            ma_done_q   <= ma_done_d;
            if_rdata_q  <= if_rdata_d;
            ma_rdata_q  <= ma_rdata_d;
        end
    end

    // Memory command is driven straight from the command registers.
    always_comb begin
        memReq       = (state_q != ST_IDLE);
        memWrite     = memReq && cmd_write_q;
        memAddr      = cmd_addr_q;
        memWriteData = cmd_wdata_q;
    end

    // Requester-facing outputs.
    always_comb begin
        ifGrant    = if_win;
        maGrant    = ma_win;
        ifDone     = if_done_q;
        maDone     = ma_done_q;
        ifReadData = if_rdata_q;
        maReadData = ma_rdata_q;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the instruction fetch stage (IF) and the memory access stage (MA). It grants the port to one requester at a time and registers the winner's command for the whole transaction. It returns completion and read data to the owner and honours pipeline flush for in-flight fetches. It sits between the IF/MA stage logic and the memory/cache bus, alongside the pipeline controller, which turns the requesters' pending state into stall requests.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, read/write data width
- STARVE_LIMIT, 4, consecutive MA grants allowed while IF waits (range 1..15)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush; discards the IF transaction
- ifReq  in  1  IF read request; level, held until ifGrant
- ifAddr  in  ADDR_WIDTH  IF read address
- ifGrant  out  1  IF request accepted this cycle
- ifDone  out  1  IF transaction complete; ifReadData valid
- ifReadData  out  DATA_WIDTH  IF read data
- maReq  in  1  MA request; level, held until maGrant
- maWrite  in  1  1 = write, 0 = read
- maAddr  in  ADDR_WIDTH  MA address
- maWriteData  in  DATA_WIDTH  MA write data
- maGrant  out  1  MA request accepted this cycle
- maDone  out  1  MA transaction complete; maReadData valid on reads
- maReadData  out  DATA_WIDTH  MA read data
- memReq  out  1  memory command valid
- memWrite  out  1  memory command is a write
- memAddr  out  ADDR_WIDTH  memory address
- memWriteData  out  DATA_WIDTH  memory write data
- memAck  in  1  memory completes the command this cycle
- memReadData  in  DATA_WIDTH  read data, valid with memAck

## Operation
- States: IDLE, IF_BUSY, MA_BUSY.
- Requests are sampled only in IDLE. In IF_BUSY and MA_BUSY they are ignored and no grant is issued.
- Arbitration in IDLE (combinational grant):
  - MA wins over IF, except when starveCnt == STARVE_LIMIT and ifReq = 1; then IF wins.
  - IF is masked (no ifGrant) in any cycle where flush = 1.
- On grant:
  - Latch the winner's address, write flag and write data into the command registers. IF transactions are always reads.
  - Next state is IF_BUSY or MA_BUSY.
- starveCnt (4-bit):
  - Increments on each maGrant while ifReq = 1, saturating at STARVE_LIMIT.
  - Clears on ifGrant, and in any IDLE cycle with ifReq = 0.
- Busy states:
  - memReq = 1 and mem* outputs are driven from the command registers.
  - memReq is held until memAck.
  - On memAck, capture memReadData into the owner's readData register and return to IDLE.
- Done: the owner's done pulses for one cycle, in the cycle after memAck. That cycle is IDLE, so a new grant may issue in it.
- Flush:
  - flush = 1 in IF_BUSY sets a kill flag.
  - The memory transaction still runs to memAck; the port is never abandoned.
  - A killed transaction produces no ifDone, and ifReadData is not updated.
  - The kill flag clears on return to IDLE.
  - flush has no effect on MA transactions.
- readData registers hold their value until the next completion for that requester.

## Timing
- Reset (rst = 0):
  - Forces state IDLE, starveCnt 0 and kill 0.
  - memReq, memWrite, ifDone and maDone are 0; memAddr, memWriteData, ifReadData and maReadData are 0.
  - ifGrant and maGrant are gated to 0 while rst = 0.
- Reset mid-transaction: the command is dropped immediately. memReq falls asynchronously and no done is issued.
- Minimum latency:
  - Grant at cycle 0 (IDLE).
  - memReq from cycle 1.
  - memAck at cycle 1 at the earliest.
  - Done at cycle 2.
  - Next grant possible at cycle 2.
  - Back-to-back throughput is one transaction per 2 cycles.
- memAck in cycle N → done in cycle N+1. memAck while IDLE is ignored.
- Simultaneous ifReq and maReq with starveCnt < STARVE_LIMIT → maGrant only.
- flush in the same cycle as memAck in IF_BUSY → ifDone suppressed.

## Test plan
- Single IF read: ifReq, ifAddr = 0x100; memAck the cycle after memReq with data 0xDEADBEEF → ifGrant at cycle 0, memAddr = 0x100, ifDone and ifReadData = 0xDEADBEEF at cycle 3.
- MA write: maWrite = 1, maAddr = 0x2000, maWriteData = 0x55 → memWrite = 1 with matching addr/data held across a 3-cycle memAck delay; exactly one maDone.
- Starvation: maReq and ifReq held continuously, STARVE_LIMIT = 4 → grants in order MA, MA, MA, MA, IF, then MA resumes.
- Flush: ifReq granted, flush pulsed during IF_BUSY, memAck 2 cycles later → memReq held until memAck, no ifDone, ifReadData unchanged.
- Reset: rst asserted low during MA_BUSY with memReq = 1 → memReq = 0 immediately, no maDone; after release, a new ifReq is granted in the first cycle.
